// File: rtl/ifu_mem_arb_pkg.sv
// Shared types for the instruction-memory port arbiter.
package ifu_mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    F1_WAIT,
    F2_REQ,
    F2_WAIT,
    PTW_WAIT,
    DRAIN
  } statetype;

  typedef enum logic {
    SRC_FETCH,
    SRC_PTW
  } srctype;

endpackage

// File: rtl/arb_age_counter.sv
// Saturating age counter: tracks how long a fetch has waited behind PTW.
module arb_age_counter #(
  parameter int MAX_WAIT = 8,
  parameter int W        = $clog2(MAX_WAIT + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_expired
);

  logic [W-1:0] r_cnt;

  // Clear has priority; increment saturates at MAX_WAIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != W'(MAX_WAIT))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt >= W'(MAX_WAIT));

endmodule

// File: rtl/ifu_mem_arb.sv
// Arbiter/sequencer for the uncached instruction-memory port shared by IFU
// demand fetches and HPTW PTE reads. Spilled fetches issue two atomic beats.
// Optional perf counters are enabled with IFU_MEM_ARB_PERF_EN.
module ifu_mem_arb
  import ifu_mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 56,
  parameter int DATA_W     = 64,
  parameter int BEAT_BYTES = 8,
  parameter int MAX_WAIT   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              FetchReq,
  input  logic [ADDR_W-1:0] FetchAdr,
  input  logic              FetchSpill,
  output logic              FetchGnt,
  output logic              FetchRespValid,
  output logic              FetchRespSecond,
  output logic [DATA_W-1:0] FetchRespData,
  input  logic              Flush,
  input  logic              PtwReq,
  input  logic [ADDR_W-1:0] PtwAdr,
  output logic              PtwGnt,
  output logic              PtwRespValid,
  output logic [DATA_W-1:0] PtwRespData,
  output logic              MemReq,
  output logic [ADDR_W-1:0] MemAdr,
  input  logic              MemReady,
  input  logic              MemRespValid,
  input  logic [DATA_W-1:0] MemRespData
`ifdef IFU_MEM_ARB_PERF_EN
  ,
  output logic [31:0]       ConflictCnt,
  output logic [31:0]       SpillCnt
`endif
);

  localparam logic [ADDR_W-1:0] LP_BEAT = ADDR_W'(BEAT_BYTES);

  statetype          r_state, w_next;
  srctype            w_src;
  logic              r_spill;
  logic [ADDR_W-1:0] r_adr2;
  logic [ADDR_W-1:0] w_adr2;
  logic              w_expired;
  logic              w_age_inc;

  assign w_adr2    = (FetchAdr & ~(LP_BEAT - 1'b1)) + LP_BEAT;
  assign w_age_inc = FetchReq & ~FetchGnt;

  arb_age_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_age (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_inc     (w_age_inc),
    .i_clr     (FetchGnt),
    .o_expired (w_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Capture beat-2 address and spill flag when a fetch is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_adr2  <= '0;
      r_spill <= 1'b0;
    end else if (FetchGnt) begin
      r_adr2  <= w_adr2;
      r_spill <= FetchSpill;
    end
  end

  // Next-state and strobe decode; every output is held low while in reset.
  always_comb begin
    w_next          = r_state;
    FetchGnt        = 1'b0;
    FetchRespValid  = 1'b0;
    FetchRespSecond = 1'b0;
    PtwGnt          = 1'b0;
    PtwRespValid    = 1'b0;
    MemReq          = 1'b0;
    MemAdr          = '0;
    w_src           = SRC_PTW;
    if (FetchReq && (!PtwReq || w_expired)) w_src = SRC_FETCH;
    if (reset_n) begin
      case (r_state)
        IDLE: begin
          MemReq = FetchReq | PtwReq;
          if (MemReq) MemAdr = (w_src == SRC_FETCH) ? FetchAdr : PtwAdr;
          if (MemReq && MemReady) begin
            if (w_src == SRC_FETCH) begin
              FetchGnt = 1'b1;
              w_next   = Flush ? DRAIN : F1_WAIT;
            end else begin
              PtwGnt = 1'b1;
              w_next = PTW_WAIT;
            end
          end
        end
        F1_WAIT: begin
          if (Flush) begin
            w_next = MemRespValid ? IDLE : DRAIN;
          end else if (MemRespValid) begin
            FetchRespValid = 1'b1;
            w_next         = r_spill ? F2_REQ : IDLE;
          end
        end
        F2_REQ: begin
          MemReq = 1'b1;
          MemAdr = r_adr2;
          if (Flush)         w_next = MemReady ? DRAIN : IDLE;
          else if (MemReady) w_next = F2_WAIT;
        end
        F2_WAIT: begin
          if (Flush) begin
            w_next = MemRespValid ? IDLE : DRAIN;
          end else if (MemRespValid) begin
            FetchRespValid  = 1'b1;
            FetchRespSecond = 1'b1;
            w_next          = IDLE;
          end
        end
        PTW_WAIT: begin
          if (MemRespValid) begin
            PtwRespValid = 1'b1;
            w_next       = IDLE;
          end
        end
        DRAIN: begin
          if (MemRespValid) w_next = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  assign FetchRespData = reset_n ? MemRespData : '0;
  assign PtwRespData   = reset_n ? MemRespData : '0;

`ifdef IFU_MEM_ARB_PERF_EN
  // Conflict cycles in IDLE and beat-2 accepts; both wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ConflictCnt <= '0;
      SpillCnt    <= '0;
    end else begin
      if ((r_state == IDLE) && FetchReq && PtwReq) ConflictCnt <= ConflictCnt + 1'b1;
      if ((r_state == F2_REQ) && MemReady)         SpillCnt    <= SpillCnt + 1'b1;
    end
  end
`else
  // Perf counters absent in this build.
`endif

endmodule
